// File: rtl/pack_build.sv
// pack_build: queues 128-bit trace frames from a 4-phase PkAvail/PkAck source
// and streams them out byte-wise (frame byte 0 first) over a DataNext/DataReady pull port.
module pack_build #(
    parameter int BUFFLENLOG2 = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PkAvail,
    input  logic [127:0] Packet,
    output logic         PkAck,
    output logic [7:0]   DataVal,
    input  logic         DataNext,
    output logic         DataReady,
    output logic         DataOverf
);
    localparam int DEPTH = 1 << BUFFLENLOG2;
    logic availM, availS;
    logic [127:0] frames [DEPTH];
    logic [BUFFLENLOG2-1:0] head, tail, headNext;
    logic [BUFFLENLOG2:0] count, countAvail, countNext;
    logic [3:0] idx, idxNext;
    logic capture, full, push, advance, pop;
    always_comb begin
        capture    = availS && !PkAck;
        full       = count == (BUFFLENLOG2+1)'(DEPTH);
        push       = capture && !full;
        advance    = DataNext && DataReady;
        pop        = advance && idx == 4'd15;
        idxNext    = advance ? idx + 4'd1 : idx;
        headNext   = pop ? head + BUFFLENLOG2'(1) : head;
        countAvail = count - (BUFFLENLOG2+1)'(pop);
        countNext  = countAvail + (BUFFLENLOG2+1)'(push);
    end
    always_ff @(posedge clk) begin
        if (push) frames[tail] <= Packet;
    end
    // A frame written on this edge becomes visible to the reader one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            availM    <= 1'b0;
            availS    <= 1'b0;
            PkAck     <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            idx       <= '0;
            DataReady <= 1'b0;
            DataVal   <= 8'h00;
            DataOverf <= 1'b0;
        end else begin
            availM    <= PkAvail;
            availS    <= availM;
            PkAck     <= availS;
            tail      <= tail + BUFFLENLOG2'(push);
            head      <= headNext;
            count     <= countNext;
            idx       <= idxNext;
            DataReady <= countAvail != '0;
            DataVal   <= countAvail != '0 ? frames[headNext][{idxNext, 3'b000} +: 8] : 8'h00;
            DataOverf <= (capture && full) || (DataOverf && countNext != '0);
        end
    end
endmodule

// File: tb/tb_pack_build.sv
// tb_pack_build: randomized frames through the handshake, byte-queue reference
// model, and a negedge monitor that scores every consumed output byte.
module tb_pack_build;
    logic clk = 0, rst = 0, PkAvail = 0, DataNext = 0;
    logic [127:0] Packet = '0;
    logic PkAck, DataReady, DataOverf;
    logic [7:0] DataVal;
    int checks = 0, failures = 0;
    logic [7:0] expQ[$];
    logic expOverf = 0;
    bit stopRand = 0;

    pack_build #(.BUFFLENLOG2(3)) dut (
        .clk(clk), .rst(rst), .PkAvail(PkAvail), .Packet(Packet), .PkAck(PkAck),
        .DataVal(DataVal), .DataNext(DataNext), .DataReady(DataReady), .DataOverf(DataOverf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frames held by the model: any partially consumed frame still occupies a slot.
    function automatic int modelFrames();
        return (expQ.size() + 15) / 16;
    endfunction

    function automatic logic [127:0] randFrame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        if (rst && DataReady && DataNext) begin
            if (expQ.size() == 0) check("unexpected_byte", DataVal, 8'hxx);
            else check("byte", DataVal, expQ.pop_front());
        end
    end

    task automatic modelPush(input logic [127:0] f);
        if (modelFrames() < 8) for (int b = 0; b < 16; b++) expQ.push_back(f[b*8 +: 8]);
        else expOverf = 1;
    endtask

    task automatic waitAck(input logic level, input int bound, input string name);
        logic got;
        got = ~level;
        for (int i = 0; i < bound && got !== level; i++) begin
            @(posedge clk); #1;
            got = PkAck;
        end
        check(name, got, level);
    endtask

    task automatic pushFrame(input logic [127:0] f);
        Packet = f;
        PkAvail = 1;
        waitAck(1, 6, "ack_rise");
        modelPush(f);
        PkAvail = 0;
        waitAck(0, 6, "ack_fall");
    endtask

    task automatic drain();
        logic done;
        done = 0;
        DataNext = 1;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #1;
            done = !DataReady;
        end
        DataNext = 0;
        check("drain_done", done, 1);
        check("drain_model_empty", expQ.size(), 0);
        expOverf = 0;
        check("overf_after_drain", DataOverf, expOverf);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] f;
        // reset held with PkAvail already high
        Packet = randFrame();
        PkAvail = 1;
        cycles(3);
        check("rst_pkack", PkAck, 0);
        check("rst_ready", DataReady, 0);
        check("rst_dataval", DataVal, 8'h00);
        check("rst_overf", DataOverf, 0);
        rst = 1;
        waitAck(1, 3, "release_ack");
        modelPush(Packet);
        PkAvail = 0;
        waitAck(0, 3, "release_ack_fall");
        drain();

        // single frame, byte n = n, pulsed DataNext
        for (int b = 0; b < 16; b++) f[b*8 +: 8] = 8'(b);
        pushFrame(f);
        cycles(1);
        check("single_ready", DataReady, 1);
        check("single_first_byte", DataVal, 8'h00);
        for (int i = 0; i < 16; i++) begin
            DataNext = 1;
            cycles(1);
            DataNext = 0;
            cycles(1);
        end
        check("single_ready_fall", DataReady, 0);
        check("single_pkack", PkAck, 0);
        check("single_model_empty", expQ.size(), 0);

        // long PkAvail high period: one capture only
        Packet = randFrame();
        PkAvail = 1;
        waitAck(1, 6, "hold_ack_rise");
        modelPush(Packet);
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            check("hold_ack_steady", PkAck, 1);
        end
        PkAvail = 0;
        waitAck(0, 3, "hold_ack_fall");
        drain();

        // overflow: nine frames without reading
        for (int i = 0; i < 9; i++) begin
            pushFrame(randFrame());
            if (i == 7) check("overf_at_8", DataOverf, 0);
        end
        check("overf_model", expOverf, 1);
        check("overf_set", DataOverf, expOverf);
        drain();

        // concurrent traffic with DataNext held, 20 frames to wrap pointers
        DataNext = 1;
        for (int i = 0; i < 20; i++) begin
            pushFrame(randFrame());
            cycles($urandom_range(12, 20));
        end
        check("concurrent_overf", DataOverf, 0);
        drain();

        // random DataNext pattern
        fork
            while (!stopRand) begin
                @(posedge clk); #1;
                DataNext = $urandom_range(0, 1);
            end
        join_none
        for (int i = 0; i < 10; i++) begin
            pushFrame(randFrame());
            cycles($urandom_range(40, 60));
        end
        stopRand = 1;
        cycles(3);
        check("random_overf", DataOverf, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pack_build.md
Name: pack_build

Overview:
- Receives complete 128-bit TPIU frames (16 bytes) from the trace interface block using a 4-phase PkAvail/PkAck handshake.
- Queues them in an internal frame FIFO.
- Presents them one byte at a time to an upstream serial/USB handler through a DataNext/DataReady pull interface.
- Sits between the trace-pin deserialiser and the host link. It flags overflow when frames arrive faster than they are drained.

Parameters:
- BUFFLENLOG2, 3, log2 of FIFO depth in 16-byte frames (default depth 8).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- PkAvail  input  1  frame-available level from the trace interface; may be asynchronous to clk.
- Packet  input  128  frame data; stable while PkAvail is high and until PkAck is seen.
- PkAck  output  1  frame-captured acknowledge (4-phase level).
- DataVal  output  8  current output byte.
- DataNext  input  1  request to advance to the next byte.
- DataReady  output  1  DataVal holds a valid byte.
- DataOverf  output  1  a frame was dropped because the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous): PkAck=0, DataReady=0, DataVal=8'h00, DataOverf=0. FIFO empty; byte index=0; synchroniser flops cleared.
- Input synchronisation: PkAvail passes through a 2-flop synchroniser (avail_s). Packet is sampled only when avail_s=1, relying on the source's stability guarantee.
- Input handshake is a 4-phase cycle on the input side.
  - IDLE: when avail_s=1 and PkAck=0, capture Packet and set PkAck=1 on the same edge.
  - While PkAck=1, wait for avail_s=0, then clear PkAck on the next edge. Only then may the next frame be accepted.
  - Exactly one capture per PkAvail high period.
- Capture with FIFO not full: write the frame to the FIFO tail; count+1.
- Capture with FIFO full: the frame is discarded. DataOverf is set and PkAck is still asserted, so the source never stalls. FIFO contents are unchanged.
- DataOverf is sticky. It clears only on reset or on the cycle the FIFO becomes empty.
- Byte order: Packet[7:0] is output first, then Packet[15:8], and so on up to Packet[127:120] (frame byte 15) last.
- Output side:
  - DataReady=1 whenever the FIFO is non-empty.
  - DataVal = byte[index] of the head frame, registered. It is valid in the same cycle DataReady is high.
  - DataNext=1 with DataReady=1 at a rising edge: the index increments and DataVal shows the next byte after that edge.
  - When index=15 is consumed, the head frame is popped, index returns to 0 and count decrements.
  - If the FIFO is then empty, DataReady drops on that edge.
- DataNext while DataReady=0 is ignored; nothing is queued.
- Simultaneous push (capture) and pop in the same cycle is legal; count is unchanged.
- A push into an empty FIFO raises DataReady one cycle after the capture edge, with DataVal=Packet[7:0].
- Pointers: head and tail are BUFFLENLOG2 bits wide and wrap naturally modulo depth. Full when count = 2^BUFFLENLOG2; count is BUFFLENLOG2+1 bits wide.
- Storage: 16-byte frames held in an inferred RAM or register array. Read is a byte select from the head frame.
- Reset asserted mid-frame: all state clears immediately and any partially read frame is lost. After release the block waits for a fresh PkAvail rising period; an already-high PkAvail is accepted after synchronisation.
- No frame decoding or filtering is performed; bytes pass through verbatim.

Test Plan:
- Reset: hold rst=0 with PkAvail=1 -> PkAck=0, DataReady=0, DataVal=00, DataOverf=0. Release -> PkAck=1 within 3 clk edges.
- Single frame:
  - Stimulus: Packet=128'h0F0E..0100 (byte n = n), PkAvail high, drop PkAvail after PkAck, then pulse DataNext 16 times.
  - Required response: DataVal sequence 00,01,..,0F. DataReady falls after the 16th DataNext and PkAck returns to 0.
- Handshake: hold PkAvail high for 20 clk -> exactly one frame queued and PkAck stays 1 throughout. Lower PkAvail -> PkAck=0 within 3 edges.
- Overflow (BUFFLENLOG2=3):
  - Stimulus: push 9 frames without reading.
  - Required response: all 9 acknowledged and DataOverf=1 after the 9th. Draining yields exactly 8 frames (the first 8, in order), then DataOverf=0 when empty.
- Concurrent traffic: push frames while continuously asserting DataNext -> byte stream equals the concatenated frames with no loss or duplication, including across pointer wrap (20 frames).
- End-to-end: feed a trace byte stream through the deserialiser on an asynchronous trace clock (widths 1, 2 and 4 bits, both phase alignments) -> output bytes equal the transmitted 16-byte frames.
